// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the fp_mac operand sequencer.
// Optional NaN/Inf detection in fp_mac_sequencer is built only when FP_MAC_SEQ_NAN_CHECK_EN is defined.
package fp_mac_pkg;
  localparam int              FP_W        = 32;
  localparam logic [FP_W-1:0] FP_ZERO     = '0;
  localparam int              FP_EXP_MSB  = 30;
  localparam int              FP_EXP_LSB  = 23;
  localparam logic [7:0]      FP_EXP_ALL1 = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_HOLD
  } mac_seq_state_t;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } fp_pair_t;

  // True for NaN and +/-Inf (all-ones exponent).
  function automatic logic fp_is_special(input logic [FP_W-1:0] v);
    return v[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ALL1;
  endfunction
endpackage

// File: rtl/mac_seq_fifo.sv
// Synchronous FIFO of operand pairs; pointers carry one wrap bit to tell full from empty.
module mac_seq_fifo
  import fp_mac_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     i_clk,
  input  logic     i_reset,
  input  logic     i_push,
  input  fp_pair_t i_wdata,
  input  logic     i_pop,
  output fp_pair_t o_rdata,
  output logic     o_full,
  output logic     o_empty
);
  localparam int AW = $clog2(DEPTH);

  fp_pair_t      r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/fp_mac_sequencer.sv
// Operand-side initiator for fp_mac: clears the accumulator, issues len pairs, drains, returns the sum.
// Define FP_MAC_SEQ_NAN_CHECK_EN to build the sticky NaN/Inf operand flag behind o_res_err.
module fp_mac_sequencer
  import fp_mac_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [FP_W-1:0]  i_in_a,
  input  logic [FP_W-1:0]  i_in_b,
  output logic             o_mac_clr,
  output logic [FP_W-1:0]  o_mac_a,
  output logic [FP_W-1:0]  o_mac_b,
  input  logic [FP_W-1:0]  i_mac_out,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [FP_W-1:0]  o_res_data,
  output logic             o_res_err
);
  localparam int DW = $clog2(MAC_LAT + 2);

  mac_seq_state_t   r_state;
  mac_seq_state_t   w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [DW-1:0]    r_dcnt;
  logic [FP_W-1:0]  r_mac_a;
  logic [FP_W-1:0]  r_mac_b;
  logic [FP_W-1:0]  r_res;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_drain_done;
  fp_pair_t         w_wdata;
  fp_pair_t         w_rdata;

  assign w_wdata = '{a: i_in_a, b: i_in_b};

  mac_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_in_valid),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_cnt_inc    = r_cnt + LEN_W'(1);
  assign w_drain_done = (r_dcnt == DW'(MAC_LAT));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_CLEAR;
      S_CLEAR: w_state_nxt = (r_len == '0) ? S_HOLD : S_ISSUE;
      S_ISSUE: begin
        // An empty FIFO is a bubble: nothing popped, the count does not advance.
        w_pop = !w_empty;
        if (w_pop && (w_cnt_inc == r_len)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_drain_done) w_state_nxt = S_HOLD;
      S_HOLD:  if (i_res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_mac_a <= FP_ZERO;
      r_mac_b <= FP_ZERO;
      r_res   <= FP_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_mac_a <= w_pop ? w_rdata.a : FP_ZERO;
      r_mac_b <= w_pop ? w_rdata.b : FP_ZERO;
      case (r_state)
        S_IDLE:  if (i_start) r_len <= i_len;
        S_CLEAR: begin
          r_cnt  <= '0;
          r_dcnt <= '0;
          if (r_len == '0) r_res <= FP_ZERO;
        end
        S_ISSUE: if (w_pop) r_cnt <= w_cnt_inc;
        S_DRAIN: begin
          r_dcnt <= r_dcnt + DW'(1);
          if (w_drain_done) r_res <= i_mac_out;
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_in_ready  = !w_full;
  assign o_mac_clr   = (r_state == S_CLEAR);
  assign o_mac_a     = r_mac_a;
  assign o_mac_b     = r_mac_b;
  assign o_res_valid = (r_state == S_HOLD);
  assign o_res_data  = r_res;

`ifdef FP_MAC_SEQ_NAN_CHECK_EN
  logic r_err;
  always_ff @(posedge i_clk) begin
    if (i_reset)                   r_err <= 1'b0;
    else if (r_state == S_CLEAR)   r_err <= 1'b0;
    else if (w_pop && (fp_is_special(w_rdata.a) || fp_is_special(w_rdata.b)))
      r_err <= 1'b1;
  end
  assign o_res_err = r_err && o_res_valid;
`else
  assign o_res_err = 1'b0;
`endif
endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Directed bench for fp_mac_sequencer with a behavioural single-cycle fp_mac beside it.
module tb_fp_mac_sequencer;
  localparam int DEPTH = 8, LEN_W = 8, MAC_LAT = 1;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, res_ready;
  logic [LEN_W-1:0] len;
  logic [31:0]      in_a, in_b, mac_out;
  logic             busy, in_ready, mac_clr, res_valid, res_err;
  logic [31:0]      mac_a, mac_b, res_data;

  int n_chk = 0, n_pass = 0;
  real mac_acc = 0.0;

  always #5 clk = ~clk;

  fp_mac_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_len(len), .o_busy(busy),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_a(in_a), .i_in_b(in_b),
    .o_mac_clr(mac_clr), .o_mac_a(mac_a), .o_mac_b(mac_b), .i_mac_out(mac_out),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
    .o_res_err(res_err)
  );

  function automatic real f2r(input logic [31:0] v);
    real m;
    int  e;
    if (v[30:23] == 8'h00 || v[30:23] == 8'hFF) return 0.0;
    m = 1.0 + real'(v[22:0]) / 8388608.0;
    e = int'(v[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (x == 0.0) return 32'h0;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'(longint'((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  // fp_mac stand-in: reset = reset | mac_clr, out updated one edge after operands.
  always @(posedge clk) begin
    if (reset || mac_clr) mac_acc = 0.0;
    else                  mac_acc = mac_acc + f2r(mac_a) * f2r(mac_b);
    mac_out <= r2f(mac_acc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic kick(input int n);
    start = 1'b1; len = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  // Called right after kick(): lat counts cycles from start to res_valid.
  task automatic wait_res(output int lat, output int clr_cnt);
    lat = 1;
    clr_cnt = int'(mac_clr);
    while (!res_valid && lat < 300) begin
      tick();
      lat++;
      clr_cnt += int'(mac_clr);
    end
    if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic job(input string tag, input int n, input logic [31:0] exp);
    int lat, clr;
    kick(n);
    wait_res(lat, clr);
    chk({tag, "_data"}, res_data, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(n + MAC_LAT + 3));
    chk({tag, "_clr"}, 32'(clr), 32'd1);
    consume();
  endtask

  initial begin
    int lat, clr;
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clr", 32'(mac_clr), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    chk("rst_mac_a", mac_a, 32'h0);
    chk("rst_mac_b", mac_b, 32'h0);
    chk("rst_data", res_data, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 3.0 * 2.0
    push(32'h40400000, 32'h40000000);
    kick(1);
    chk("j1_clr_t1", 32'(mac_clr), 32'd1);
    chk("j1_busy", 32'(busy), 32'd1);
    wait_res(lat, clr);
    chk("j1_data", res_data, 32'h40C00000);
    chk("j1_lat", 32'(lat), 32'd5);
    chk("j1_clr_once", 32'(clr), 32'd1);
    chk("j1_err", 32'(res_err), 32'd0);
    consume();
    chk("j1_idle", 32'(busy), 32'd0);

    // 3*2 + 1*4, then 2*2 in a fresh job
    push(32'h40400000, 32'h40000000);
    push(32'h3F800000, 32'h40800000);
    job("j2", 2, 32'h41200000);
    push(32'h40000000, 32'h40000000);
    job("j3", 1, 32'h40800000);

    // len=0: straight to HOLD with zero, buffered pair left alone
    push(32'h40400000, 32'h40000000);
    kick(0);
    wait_res(lat, clr);
    chk("z_data", res_data, 32'h0);
    chk("z_lat", 32'(lat), 32'd2);
    chk("z_mac_a", mac_a, 32'h0);
    consume();
    job("z_after", 1, 32'h40C00000);

    // Fill FIFO; an extra 2*2 push while full must be dropped
    for (int i = 0; i < DEPTH; i++) push(32'h3F800000, 32'h3F800000);
    chk("full_ready", 32'(in_ready), 32'd0);
    push(32'h40000000, 32'h40000000);
    chk("full_ready2", 32'(in_ready), 32'd0);
    job("full", DEPTH, 32'h41000000);
    push(32'h40400000, 32'h40000000);
    job("full_after", 1, 32'h40C00000);

    // Bubbles: empty FIFO at start, pairs k*1.0 (k=1..8) trickle in with gaps; sum 36.0
    kick(DEPTH);
    for (int k = 1; k <= DEPTH; k++) begin
      if (k % 2 == 1) begin tick(); tick(); end
      push(r2f(real'(k)), 32'h3F800000);
    end
    wait_res(lat, clr);
    chk("bub_data", res_data, 32'h42100000);
    consume();

    // HOLD stall with start asserted
    push(32'h40400000, 32'h40000000);
    kick(1);
    wait_res(lat, clr);
    start = 1'b1; len = LEN_W'(5);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_data", res_data, 32'h40C00000);
    end
    start = 1'b0;
    consume();
    chk("hold_idle", 32'(busy), 32'd0);
    tick();
    chk("hold_no_start", 32'(busy), 32'd0);

    // Reset mid-ISSUE
    for (int i = 0; i < 4; i++) push(32'h40400000, 32'h40000000);
    kick(8);
    tick(); tick();
    chk("mid_mac_a", mac_a, 32'h40400000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_valid", 32'(res_valid), 32'd0);
    chk("mr_mac_a", mac_a, 32'h0);
    chk("mr_mac_b", mac_b, 32'h0);
    chk("mr_data", res_data, 32'h0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    push(32'h40000000, 32'h40000000);
    job("mr_after", 1, 32'h40800000);

`ifdef FP_MAC_SEQ_NAN_CHECK_EN
    push(32'h7FC00000, 32'h3F800000);
    kick(1);
    wait_res(lat, clr);
    chk("nan_err", 32'(res_err), 32'd1);
    consume();
    push(32'h40400000, 32'h40000000);
    kick(1);
    wait_res(lat, clr);
    chk("nan_cleared", 32'(res_err), 32'd0);
    consume();
`else
    push(32'h7FC00000, 32'h3F800000);
    kick(1);
    wait_res(lat, clr);
    chk("nan_off_err", 32'(res_err), 32'd0);
    consume();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_mac_sequencer.md
# fp_mac_sequencer

- Drives the existing single-precision `fp_mac` from the operand side, as the initiator for that accumulator.
- Buffers IEEE-754 operand pairs through a valid/ready stream and clears the MAC at the start of each job.
- Issues exactly `len` pairs, waits for the MAC pipeline to settle, then returns the accumulated result on a valid/ready result port.
- Sits between the operand source (DMA or test harness) and `fp_mac`, replacing hand-sequenced `a`/`b` stimulus.

## Interface
- `DEPTH`, 8: operand FIFO entries (power of two, ≥2)
- `LEN_W`, 8: width of job length / pair counter
- `MAC_LAT`, 1: `fp_mac` cycles from operand visible to accumulated `out` updated

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin job; sampled only in IDLE
- `len` in LEN_W: pairs in job, captured with `start`
- `busy` out 1: high in every state except IDLE
- `in_valid` in 1 / `in_ready` out 1: operand push handshake
- `in_a`, `in_b` in 32: operand pair
- `mac_clr` out 1: ORed with `reset` into `fp_mac.reset`
- `mac_a`, `mac_b` out 32: to `fp_mac.a` / `fp_mac.b`
- `mac_out` in 32: from `fp_mac.out`
- `res_valid` out 1 / `res_ready` in 1: result handshake
- `res_data` out 32: accumulated sum
- `res_err` out 1: NaN/Inf seen in job (see Configuration)

## Operation
- FIFO:
  - Push when `in_valid && in_ready`; `in_ready = !full`.
  - Accepted in any state, so the next job can prefetch.
  - Simultaneous push and pop is legal when neither full nor empty.
- FSM states are IDLE, CLEAR, ISSUE, DRAIN, HOLD.
- **IDLE**
  - `start` captures `len` and goes to CLEAR.
  - `start` is ignored in every other state.
- **CLEAR**
  - `mac_clr` = 1 for exactly one cycle.
  - Next state is ISSUE, or HOLD with `res_data` = 32'h00000000 if `len` == 0.
- **ISSUE**
  - Each cycle with FIFO non-empty: pop one pair, load it into the `mac_a`/`mac_b` registers, increment the issue counter.
  - An empty FIFO is a bubble: load 32'h0 into both. 0×0 adds +0 to the accumulator.
  - When the counter reaches `len`, go to DRAIN.
  - No pops occur outside ISSUE.
- **DRAIN**
  - `mac_a`/`mac_b` = 0.
  - Wait MAC_LAT+1 cycles, then capture `mac_out` into `res_data` and go to HOLD.
- **HOLD**
  - `res_valid` = 1, `res_data` stable.
  - `res_ready` goes to IDLE on the same edge.
  - The earliest new `start` is the cycle after.
- Counter arithmetic is unsigned LEN_W with no wrap: `len` = 2^LEN_W−1 is the maximum.

## Timing
- Reset values:
  - `busy`, `mac_clr`, `res_valid`, `res_err` = 0.
  - `mac_a`, `mac_b`, `res_data` = 0.
  - `in_ready` = 1 (FIFO emptied).
  - State = IDLE.
- Reset mid-job aborts immediately. Buffered pairs are discarded and the MAC is cleared by the same `reset`.
- `start` at edge t: `mac_clr` is high during cycle t+1, and the first pair is visible on `mac_a`/`mac_b` at cycle t+2 if the FIFO was non-empty.
- Issue throughput is 1 pair per cycle.
- Latency from `start` to `res_valid`: `len` + MAC_LAT + 3 cycles with no bubbles.
- `res_valid` held indefinitely while `res_ready` is low; `in_ready` is still governed by the FIFO.

## Configuration
- `FP_MAC_SEQ_NAN_CHECK_EN`
  - **Defined:** each issued operand with exponent 8'hFF sets a sticky error flag.
  - The flag is cleared in CLEAR and presented as `res_err` alongside `res_valid`.
  - **Undefined:** `res_err` is tied to 0 and no check logic is built.
  - The port exists in both builds.

## Structure
- Package `fp_mac_pkg`:
  - `FP_W` = 32, `FP_ZERO`, `FP_EXP_MSB`/`FP_EXP_LSB`, `FP_EXP_ALL1` = 8'hFF.
  - State enum `mac_seq_state_t`.
- Sub-module `mac_seq_fifo`:
  - Synchronous FIFO of 64-bit pairs with `full`/`empty` and registered pointers.
  - Sequencer FSM, counters and output registers stay in `fp_mac_sequencer`.

## Test plan
- Push (40400000, 40000000), `start` with `len`=1:
  - `mac_clr` pulses once.
  - `res_data` = 40C00000 (6.0).
  - `res_valid` arrives at `start`+MAC_LAT+4.
- Push (3.0, 2.0) and (1.0, 4.0), `len`=2:
  - `res_data` = 41200000 (10.0).
  - Then a second job (2.0, 2.0), `len`=1 gives 40800000, proving the clear.
- `len`=0: HOLD with `res_data` = 00000000, no pops, FIFO contents untouched.
- Fill FIFO to DEPTH:
  - `in_ready` low, and the extra push is not accepted.
  - `len`=DEPTH job with intermittent `in_valid` gaps: bubbles drive zeros and the sum is still correct.
- Hold `res_ready` low 10 cycles in HOLD: `res_valid`/`res_data` stable, `start` ignored.
- `reset` asserted mid-ISSUE:
  - All outputs return to reset values next cycle and the FIFO is empty.
  - With the macro defined, pair (7FC00000, 3F800000) sets `res_err` = 1.
